async_fifo: RTL and testbench

- Parameterised FIFO buffer of 2**ASIZE entries, each DSIZE bits, with first-word-fall-through read data and full/empty status flags.
- Keeps the producer/consumer port naming of the team's FIFO family (w* write side, r* read side).
- Both sides run on one clock, `wclk`, and share one reset, `wrst_n`.
- Sits between a data producer and a consumer as an elastic buffer; both sides use `wfull`/`rempty` for flow control.

---
 rtl/async_fifo.sv | 57 +++++
 tb/tb_async_fifo.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/async_fifo.sv
// Elastic FIFO buffer with first-word-fall-through read data and registered full/empty flags.
// Both ports share wclk; pointers carry an extra wrap bit to tell full from empty.
module async_fifo #(
   parameter int DSIZE = 8,
   parameter int ASIZE = 4
) (
   input  logic             wclk,
   input  logic             wrst_n,
   input  logic             winc,
   input  logic [DSIZE-1:0] wdata,
   input  logic             rinc,
   output logic [DSIZE-1:0] rdata,
   output logic             wfull,
   output logic             rempty
);

   localparam int DEPTH = 1 << ASIZE;

   logic [DSIZE-1:0] mem [DEPTH];
   logic [ASIZE:0]   wptr;
   logic [ASIZE:0]   rptr;
   logic [ASIZE:0]   wptr_nxt;
   logic [ASIZE:0]   rptr_nxt;
   logic             wr_en;
   logic             rd_en;

   assign wr_en    = winc & ~wfull;
   assign rd_en    = rinc & ~rempty;
   assign wptr_nxt = wptr + {{ASIZE{1'b0}}, wr_en};
   assign rptr_nxt = rptr + {{ASIZE{1'b0}}, rd_en};

   // Storage is deliberately left out of reset.
   always_ff @(posedge wclk) begin
      if (wr_en) begin
         mem[wptr[ASIZE-1:0]] <= wdata;
      end
   end

   // Flags come from the post-edge pointers so they track the edge with no extra lag.
   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) begin
         wptr   <= '0;
         rptr   <= '0;
         rempty <= 1'b1;
         wfull  <= 1'b0;
      end else begin
         wptr   <= wptr_nxt;
         rptr   <= rptr_nxt;
         rempty <= (rptr_nxt == wptr_nxt);
         wfull  <= (wptr_nxt[ASIZE] != rptr_nxt[ASIZE]) &&
                   (wptr_nxt[ASIZE-1:0] == rptr_nxt[ASIZE-1:0]);
      end
   end

   assign rdata = mem[rptr[ASIZE-1:0]];

endmodule

// File: tb/tb_async_fifo.sv
// Randomized scoreboard bench for async_fifo: a queue model tracks contents, a monitor
// compares flags and head data against it on every falling edge.
module tb_async_fifo;

   localparam int DSIZE = 8;
   localparam int ASIZE = 4;
   localparam int DEPTH = 1 << ASIZE;

   logic             wclk;
   logic             wrst_n;
   logic             winc;
   logic [DSIZE-1:0] wdata;
   logic             rinc;
   logic [DSIZE-1:0] rdata;
   logic             wfull;
   logic             rempty;

   int checks = 0;
   int errors = 0;

   logic [DSIZE-1:0] exp_q [$];

   async_fifo #(.DSIZE(DSIZE), .ASIZE(ASIZE)) dut (
      .wclk   (wclk),
      .wrst_n (wrst_n),
      .winc   (winc),
      .wdata  (wdata),
      .rinc   (rinc),
      .rdata  (rdata),
      .wfull  (wfull),
      .rempty (rempty)
   );

   initial begin
      wclk = 1'b0;
      forever #5 wclk = ~wclk;
   end

   // Reference model: a queue of accepted words, updated by the acceptance rules.
   always @(posedge wclk) begin
      if (wrst_n) begin
         automatic int  occ  = exp_q.size();
         automatic bit  do_r = rinc && (occ > 0);
         automatic bit  do_w = winc && (occ < DEPTH);
         if (do_r) void'(exp_q.pop_front());
         if (do_w) exp_q.push_back(wdata);
      end
   end

   always @(negedge wrst_n) exp_q.delete();

   // Monitor
   always @(negedge wclk) begin
      automatic int occ = exp_q.size();
      checks++;
      if (rempty !== (occ == 0)) begin
         errors++;
         $display("FAIL rempty: got %b expected %b (occ %0d) t=%0t", rempty, (occ == 0), occ, $time);
      end
      checks++;
      if (wfull !== (occ == DEPTH)) begin
         errors++;
         $display("FAIL wfull: got %b expected %b (occ %0d) t=%0t", wfull, (occ == DEPTH), occ, $time);
      end
      if (occ > 0) begin
         checks++;
         if (rdata !== exp_q[0]) begin
            errors++;
            $display("FAIL rdata: got %h expected %h t=%0t", rdata, exp_q[0], $time);
         end
      end
   end

   task automatic step(input bit w, input logic [DSIZE-1:0] d, input bit r);
      winc  = w;
      wdata = d;
      rinc  = r;
      @(posedge wclk);
      #1;
   endtask

   initial begin
      int nw;
      winc   = 1'b0;
      rinc   = 1'b0;
      wdata  = '0;
      wrst_n = 1'b1;
      #1 wrst_n = 1'b0;

      // Reset held with requests asserted
      for (int i = 0; i < 5; i++) step(1'b1, 8'h33, 1'b1);
      winc = 1'b0;
      rinc = 1'b0;
      wrst_n = 1'b1;
      step(1'b0, 8'h00, 1'b0);

      // Single word
      step(1'b1, 8'hA5, 1'b0);
      step(1'b0, 8'h00, 1'b0);
      step(1'b0, 8'h00, 1'b1);
      step(1'b0, 8'h00, 1'b0);

      // Fill, overflow attempt, drain
      for (int i = 0; i < DEPTH; i++) step(1'b1, DSIZE'(i), 1'b0);
      step(1'b1, 8'hFF, 1'b0);
      for (int i = 0; i < DEPTH; i++) step(1'b0, 8'h00, 1'b1);
      step(1'b0, 8'h00, 1'b0);

      // Interleaved random traffic
      nw = 0;
      for (int c = 0; c < 48; c++) begin
         automatic bit w = (c % 2 == 0) && (nw < 16);
         automatic bit r = (c >= 8) && (c % 2 == 1) && !rempty;
         if (w) nw++;
         step(w, DSIZE'($urandom), r);
      end
      while (!rempty) step(1'b0, 8'h00, 1'b1);

      // Simultaneous read/write at half occupancy, across a pointer wrap
      for (int i = 0; i < 8; i++) step(1'b1, DSIZE'($urandom), 1'b0);
      for (int i = 0; i < 20; i++) step(1'b1, DSIZE'($urandom), 1'b1);
      // Top up to full, then read+write together
      for (int i = 0; i < 8; i++) step(1'b1, DSIZE'($urandom), 1'b0);
      step(1'b1, DSIZE'($urandom), 1'b1);
      step(1'b0, 8'h00, 1'b0);
      for (int i = 0; i < DEPTH; i++) step(1'b0, 8'h00, 1'b1);

      // Random mixed traffic
      for (int i = 0; i < 200; i++)
         step(1'($urandom_range(0, 1)), DSIZE'($urandom), 1'($urandom_range(0, 1)));
      step(1'b0, 8'h00, 1'b0);

      // Mid-operation asynchronous reset with 5 entries queued
      while (!rempty) step(1'b0, 8'h00, 1'b1);
      for (int i = 0; i < 5; i++) step(1'b1, DSIZE'($urandom), 1'b0);
      winc = 1'b0;
      #2 wrst_n = 1'b0;
      #1;
      checks++;
      if (rempty !== 1'b1 || wfull !== 1'b0) begin
         errors++;
         $display("FAIL async_reset: rempty=%b wfull=%b expected rempty=1 wfull=0", rempty, wfull);
      end
      @(negedge wclk);
      #1 wrst_n = 1'b1;
      @(posedge wclk);
      #1;
      step(1'b1, 8'h5A, 1'b0);
      step(1'b0, 8'h00, 1'b1);
      step(1'b0, 8'h00, 1'b0);
      @(negedge wclk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
